assoc_dcache: RTL and testbench
===============================

ASSOC_DCACHE -- requirements
Module: assoc_dcache

Interface
REQ-001 SHALL have parameter WAYS, 2, associativity; legal 1, 2, 4.
REQ-002 SHALL have parameter SETS, 256, sets per way; power of two, 2..1024.
REQ-003 SHALL have parameter DATA_WIDTH, 32, word and address width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cpu_req  in  1  request valid; held until cpu_ready.
REQ-007 SHALL have port cpu_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port cpu_addr  in  32  byte address.
REQ-009 SHALL have port cpu_wdata  in  32  store data, lane-aligned.
REQ-010 SHALL have port cpu_size  in  2  byte_format: Word, HalfWord, Byte.
REQ-011 SHALL have port cpu_rdata  out  32  full load word; sub-word extraction is done downstream.
REQ-012 SHALL have port cpu_ready  out  1  one-cycle completion pulse.
REQ-013 SHALL have ports mem_req/mem_we/mem_addr/mem_wdata/mem_be  out  1/1/32/32/4  backing-memory request.
REQ-014 SHALL have ports mem_rdata/mem_ack  in  32/1  memory return; ack valid one cycle.

Function
REQ-015 SHALL decode: offset = addr[1:0], index = addr[log2(SETS)+1:2], tag = addr[31:log2(SETS)+2].
REQ-016 SHALL register one word per line, with a valid bit and tag per way.
REQ-017 SHALL define a hit as any way in the indexed set with valid=1 and a matching tag; at most one way SHALL match.
REQ-018 SHALL use FSM states IDLE, RD_MISS and WR_THRU.
REQ-019 SHALL handle a load hit in IDLE as follows: cpu_rdata = hit way data, cpu_ready=1 in the same cycle (0 wait), and the hit way becomes MRU.
REQ-020 SHALL handle a load miss in IDLE as follows: cpu_ready=0, next state RD_MISS.
REQ-021 SHALL, in RD_MISS, assert mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}; on mem_ack, write mem_rdata, the tag and valid=1 into the victim way, mark it MRU, and go to IDLE; the retried lookup then hits, giving total miss latency = ack cycle + 1.
REQ-022 SHALL select the victim as the lowest-index invalid way, else the LRU way.
REQ-023 SHALL handle a store in IDLE by going to WR_THRU with cpu_ready=0 (write-through, no-write-allocate).
REQ-024 SHALL, in WR_THRU, assert mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_be from cpu_size/offset (Word 1111; HalfWord 0011<<offset; Byte 0001<<offset).
REQ-025 SHALL, on mem_ack in WR_THRU, assert cpu_ready=1, and on a hit merge the enabled bytes into the line and make it MRU; a store miss SHALL leave the cache unchanged; next state IDLE.
REQ-026 SHALL hold mem_* outputs stable until mem_ack; mem_req=0 in IDLE.
REQ-027 SHALL keep LRU order per set as distinct log2(WAYS)-bit ages: the accessed way becomes 0, younger ways increment, and the way with age WAYS-1 is LRU; with WAYS=1 there is no LRU state.
REQ-028 SHALL ignore mem_ack in IDLE.
REQ-029 SHALL not start a new request in the cpu_ready cycle; the next request is evaluated on the following cycle.

Reset
REQ-030 SHALL, on rst, asynchronously clear all valid bits, set state IDLE, set way w age = w, and drive cpu_ready, mem_req, mem_we, mem_be to 0 and cpu_rdata to 0.
REQ-031 SHALL, when rst is asserted mid-RD_MISS or mid-WR_THRU, drop mem_req immediately and perform no fill or merge; a later mem_ack is ignored.
REQ-032 SHALL not reset the data and tag arrays.

Configuration
REQ-033 SHALL, when macro ASSOC_DCACHE_STATS_EN is defined, add output ports hit_count and miss_count (32 each) that saturate at 0xFFFFFFFF, reset to 0, count once per completed load (hit counts hit, RD_MISS entry counts miss), and exclude stores.
REQ-034 SHALL, without ASSOC_DCACHE_STATS_EN, have neither the ports nor the counters.

Structure
REQ-035 SHALL place in types_pkg: the cache_state enum (IDLE, RD_MISS, WR_THRU), the reuse of byte_format, and a byte-enable width constant BE_WIDTH=DATA_WIDTH/8.
REQ-036 SHALL keep per-set LRU ages and victim selection in a sub-module cache_lru (inputs index, access way, access strobe; output victim way).

Verification
REQ-037 SHALL verify a cold load 0x00000100 (mem_rdata 0xDEADBEEF, ack after 3 cycles): mem_addr=0x00000100, cpu_ready on the cycle after ack, cpu_rdata=0xDEADBEEF; a repeat load gives ready in 0 waits with no mem_req.
REQ-038 SHALL verify conflict with WAYS=2, SETS=256: loads 0x100, 0x500, 0x100, then 0x900: 0x900 evicts 0x500; a reload of 0x100 hits and 0x500 misses.
REQ-039 SHALL verify a store Byte 0xAB to 0x103 after 0x100 is cached as 0x11223344: mem_be=1000, mem_wdata lane 3 = 0xAB; a subsequent load returns 0xAB223344 with no mem_req.
REQ-040 SHALL verify a store-miss to 0x2000: a memory write occurs, then a load of 0x2000 misses (no allocate).
REQ-041 SHALL verify rst asserted 1 cycle into RD_MISS: mem_req=0 the same cycle, a late ack is ignored, and the next load of the same address misses.
REQ-042 SHALL verify, with ASSOC_DCACHE_STATS_EN, that 1 miss + 2 hits gives hit_count=2 and miss_count=1.

Source files
------------

// File: rtl/types_pkg.sv
// types_pkg: shared types and constants for the assoc_dcache slice.
// Holds the controller state encoding, the CPU access-size format and the
// byte-enable helper used by the write-through path.
package types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } cache_state;

  typedef enum logic [1:0] {
    Word     = 2'd0,
    HalfWord = 2'd1,
    Byte     = 2'd2
  } byte_format;

  localparam int DATA_WIDTH_DFLT = 32;
  localparam int BE_WIDTH        = DATA_WIDTH_DFLT / 8;

  // Byte enables for a store of the given size at the given byte offset.
  // Encodings outside the enum fall back to a full word.
  function automatic logic [BE_WIDTH-1:0] size_to_be(input byte_format sz,
                                                     input logic [1:0] off);
    logic [BE_WIDTH-1:0] be;
    case (sz)
      HalfWord: be = BE_WIDTH'(2'b11) << off;
      Byte:     be = BE_WIDTH'(1'b1) << off;
      default:  be = '1;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// cache_lru: per-set LRU ages and victim selection for assoc_dcache.
// Each way in a set holds a distinct age; 0 is most recently used and
// WAYS-1 is least recently used. A direct-mapped build keeps no state.
module cache_lru #(
  parameter  int WAYS = 2,
  parameter  int SETS = 256,
  localparam int IW   = $clog2(SETS),
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   index_i,
  input  logic [WW-1:0]   access_way_i,
  input  logic            access_i,
  input  logic [WAYS-1:0] valid_i,
  output logic [WW-1:0]   victim_o
);

  logic [WW-1:0] lru_way;

  if (WAYS > 1) begin : g_ages
    logic [SETS-1:0][WAYS-1:0][WW-1:0] age_q;
    logic [WW-1:0]                     acc_age;

    assign acc_age = age_q[index_i][access_way_i];

    // Age update: accessed way becomes 0, ways younger than it age by one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            age_q[s][w] <= WW'(w);
          end
        end
      end else if (access_i) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WW'(w) == access_way_i) begin
            age_q[index_i][w] <= '0;
          end else if (age_q[index_i][w] < acc_age) begin
            age_q[index_i][w] <= age_q[index_i][w] + WW'(1);
          end
        end
      end
    end

    // Locate the oldest way in the indexed set
    always_comb begin
      lru_way = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[index_i][w] == WW'(WAYS - 1)) lru_way = WW'(w);
      end
    end
  end else begin : g_direct
    logic unused_ok;
    assign unused_ok = ^{clk, rst, index_i, access_way_i, access_i};
    assign lru_way   = '0;
  end

  // Victim: lowest-index empty way, otherwise the LRU way
  always_comb begin
    victim_o = lru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_o = WW'(w);
    end
  end

endmodule

// File: rtl/assoc_dcache.sv
// assoc_dcache: set-associative, one-word-per-line, write-through,
// no-write-allocate data cache with a single outstanding memory request.
// Load hits complete combinationally in IDLE; misses fill the victim way
// and then retry the lookup. Optional load statistics are compiled in
// with the macro ASSOC_DCACHE_STATS_EN.
module assoc_dcache
  import types_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [1:0]            cpu_size,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
`ifdef ASSOC_DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = DATA_WIDTH - IW - 2;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  cache_state state_q, state_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [TW-1:0]             tag_q  [WAYS][SETS];
  logic [DATA_WIDTH-1:0]     data_q [WAYS][SETS];

  logic [1:0]            offset;
  logic [IW-1:0]         index;
  logic [TW-1:0]         tag;
  logic [WAYS-1:0]       set_valid;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  logic [WW-1:0]         hit_way;
  logic [WW-1:0]         victim_way;
  logic [WW-1:0]         lru_way_sel;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [DATA_WIDTH-1:0] merged;
  logic [BE_WIDTH-1:0]   store_be;
  logic                  load_hit;
  logic                  fill;
  logic                  store_hit_done;
  logic                  lru_access;

  assign offset    = cpu_addr[1:0];
  assign index     = cpu_addr[IW+1:2];
  assign tag       = cpu_addr[DATA_WIDTH-1:IW+2];
  assign set_valid = valid_q[index];
  assign store_be  = size_to_be(byte_format'(cpu_size), offset);

  // Tag compare across the indexed set; at most one way can match
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = set_valid[w] && (tag_q[w][index] == tag);
      if (hit_vec[w]) hit_way = WW'(w);
    end
  end

  assign hit      = |hit_vec;
  assign hit_data = data_q[hit_way][index];

  // Merge the enabled store lanes over the currently cached word
  always_comb begin
    merged = hit_data;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (store_be[b]) merged[8*b +: 8] = cpu_wdata[8*b +: 8];
    end
  end

  assign load_hit       = (state_q == IDLE) && cpu_req && !cpu_we && hit;
  assign fill           = (state_q == RD_MISS) && mem_ack;
  assign store_hit_done = (state_q == WR_THRU) && mem_ack && hit;
  assign lru_access     = load_hit || fill || store_hit_done;
  assign lru_way_sel    = fill ? victim_way : hit_way;

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk          (clk),
    .rst          (rst),
    .index_i      (index),
    .access_way_i (lru_way_sel),
    .access_i     (lru_access),
    .valid_i      (set_valid),
    .victim_o     (victim_way)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; IDLE ignores mem_ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we)    state_d = WR_THRU;
          else if (!hit) state_d = RD_MISS;
        end
      end
      RD_MISS: if (mem_ack) state_d = IDLE;
      WR_THRU: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything derives from state so reset silences them at once
  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      IDLE: begin
        if (load_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = hit_data;
        end
      end
      RD_MISS: begin
        mem_req  = 1'b1;
        mem_addr = {cpu_addr[DATA_WIDTH-1:2], 2'b00};
      end
      WR_THRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_be    = store_be;
        cpu_ready = mem_ack;
      end
      default: ;
    endcase
  end

  // Valid bits: cleared by reset, set when a fill lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       valid_q <= '0;
    else if (fill) valid_q[index][victim_way] <= 1'b1;
  end

  // Tag/data arrays are not reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim_way][index]  <= tag;
      data_q[victim_way][index] <= mem_rdata;
    end else if (store_hit_done) begin
      data_q[hit_way][index] <= merged;
    end
  end

`ifdef ASSOC_DCACHE_STATS_EN
  logic        retry_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Load statistics; the post-fill retry hit belongs to the miss, not a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (fill)          retry_q <= 1'b1;
      else if (load_hit) retry_q <= 1'b0;
      if (load_hit && !retry_q && (hit_cnt_q != '1))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && cpu_req && !cpu_we && !hit && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_dcache.sv
// tb_assoc_dcache: directed bench for assoc_dcache (WAYS=2, SETS=256).
// A behavioural memory answers requests after a programmable delay; load
// expectations go through a scoreboard queue and are checked on cpu_ready.
module tb_assoc_dcache;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack   = 1'b0;
`ifdef ASSOC_DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [31:0] sb [$];
  logic [31:0] mem_model [logic [31:0]];

  int          ack_dly    = 3;
  bit          ack_en     = 1'b1;
  bit          inject_ack = 1'b0;
  int          wait_cnt   = 0;
  int          req_cycles = 0;
  int          ack_cyc    = -1;
  logic [31:0] ack_addr   = 32'd0;

  assoc_dcache #(
    .WAYS       (2),
    .SETS       (256),
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_size   (cpu_size),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef ASSOC_DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks a request after ack_dly waiting cycles
  always @(negedge clk) begin
    logic [31:0] wa;
    logic [31:0] word;
    mem_ack = 1'b0;
    if (inject_ack) begin
      mem_ack    = 1'b1;
      mem_rdata  = 32'h0BAD_0BAD;
      inject_ack = 1'b0;
      wait_cnt   = 0;
    end else if (mem_req) begin
      req_cycles++;
      if (ack_en && wait_cnt >= ack_dly) begin
        wait_cnt = 0;
        mem_ack  = 1'b1;
        ack_cyc  = cyc;
        ack_addr = mem_addr;
        wa       = {mem_addr[31:2], 2'b00};
        word     = mem_model.exists(wa) ? mem_model[wa] : 32'd0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
          end
          mem_model[wa] = word;
        end else begin
          mem_rdata = word;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input bit exp_hit,
                    input string tag);
    int          n;
    int          start_req;
    logic [31:0] e;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = a;
    cpu_size  = Word;
    cpu_wdata = 32'd0;
    sb.push_back(exp);
    start_req = req_cycles;
    n = 0;
    #1;
    while (!cpu_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    if (!cpu_ready) begin
      chkint({tag, "_timeout"}, int'(cpu_ready), 1);
    end else begin
      chk32({tag, "_rdata"}, cpu_rdata, e);
      if (exp_hit) begin
        chkint({tag, "_hit_lat"}, n, 0);
        chkint({tag, "_hit_noreq"}, req_cycles - start_req, 0);
      end else begin
        chkint({tag, "_miss_lat"}, n, ack_dly + 2);
        chk32({tag, "_miss_addr"}, ack_addr, {a[31:2], 2'b00});
        chkint({tag, "_ready_after_ack"}, cyc, ack_cyc + 1);
      end
    end
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                    input logic [3:0] exp_be, input string tag);
    int n;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_size  = sz;
    n = 0;
    #1;
    while (!cpu_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cpu_ready) begin
      chkint({tag, "_timeout"}, int'(cpu_ready), 1);
    end else begin
      chk32({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
      chkint({tag, "_we"}, int'(mem_we), 1);
      chk32({tag, "_wdata"}, mem_wdata, d);
      chk32({tag, "_addr"}, mem_addr, a);
      chkint({tag, "_lat"}, n, ack_dly + 1);
    end
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    cpu_size  = Word;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chkint("rst_ready", int'(cpu_ready), 0);
    chkint("rst_memreq", int'(mem_req), 0);
    chkint("rst_memwe", int'(mem_we), 0);
    chk32("rst_membe", {28'd0, mem_be}, 32'd0);
    chk32("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold load then warm hits (including a non-zero offset)
    mem_model[32'h100] = 32'hDEAD_BEEF;
    ld(32'h100, 32'hDEAD_BEEF, 1'b0, "cold");
    ld(32'h100, 32'hDEAD_BEEF, 1'b1, "warm");
    ld(32'h103, 32'hDEAD_BEEF, 1'b1, "warm_off3");

    // Two-way conflict in set 0x40
    apply_reset();
    mem_model[32'h100] = 32'hAAAA_0100;
    mem_model[32'h500] = 32'hBBBB_0500;
    mem_model[32'h900] = 32'hCCCC_0900;
    ld(32'h100, 32'hAAAA_0100, 1'b0, "cf_a");
    ld(32'h500, 32'hBBBB_0500, 1'b0, "cf_b");
    ld(32'h100, 32'hAAAA_0100, 1'b1, "cf_a_hit");
    ld(32'h900, 32'hCCCC_0900, 1'b0, "cf_c");
    ld(32'h100, 32'hAAAA_0100, 1'b1, "cf_a_kept");
    ld(32'h500, 32'hBBBB_0500, 1'b0, "cf_b_evicted");

    // Store hits merge bytes into the cached word
    apply_reset();
    mem_model[32'h100] = 32'h1122_3344;
    ld(32'h100, 32'h1122_3344, 1'b0, "sh_fill");
    st(32'h103, 32'hAB00_0000, Byte, 4'b1000, "sh_byte");
    ld(32'h100, 32'hAB22_3344, 1'b1, "sh_byte_rd");
    st(32'h102, 32'h5566_0000, HalfWord, 4'b1100, "sh_half");
    ld(32'h100, 32'h5566_3344, 1'b1, "sh_half_rd");
    st(32'h100, 32'h0102_0304, Word, 4'b1111, "sh_word");
    ld(32'h100, 32'h0102_0304, 1'b1, "sh_word_rd");
    chk32("sh_memword", mem_model[32'h100], 32'h0102_0304);

    // Store miss writes memory but does not allocate
    st(32'h2000, 32'hCAFE_F00D, Word, 4'b1111, "smiss");
    chk32("smiss_memword", mem_model[32'h2000], 32'hCAFE_F00D);
    ld(32'h2000, 32'hCAFE_F00D, 1'b0, "smiss_rd");

    // Reset one cycle into RD_MISS, then a stray ack
    apply_reset();
    mem_model[32'h300] = 32'h3030_3030;
    ack_en = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h300;
    cpu_size = Word;
    n = 0;
    #1;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chkint("rmid_entered", int'(mem_req), 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chkint("rmid_req_drop", int'(mem_req), 0);
    @(negedge clk);
    rst     = 1'b0;
    cpu_req = 1'b0;
    #2;
    inject_ack = 1'b1;
    @(negedge clk);
    #1;
    chkint("late_ack_ready", int'(cpu_ready), 0);
    chkint("late_ack_req", int'(mem_req), 0);
    @(negedge clk);
    #1;
    chkint("late_ack_idle", int'(mem_req), 0);
    ack_en = 1'b1;
    ld(32'h300, 32'h3030_3030, 1'b0, "rmid_reload");

`ifdef ASSOC_DCACHE_STATS_EN
    // One miss and two hits
    apply_reset();
    #1;
    chk32("stat_rst_hit", hit_count, 32'd0);
    chk32("stat_rst_miss", miss_count, 32'd0);
    mem_model[32'h100] = 32'h5151_5151;
    ld(32'h100, 32'h5151_5151, 1'b0, "stat_miss");
    ld(32'h100, 32'h5151_5151, 1'b1, "stat_hit1");
    ld(32'h100, 32'h5151_5151, 1'b1, "stat_hit2");
    st(32'h100, 32'h0000_0000, Word, 4'b1111, "stat_store");
    @(negedge clk);
    #1;
    chk32("stat_hits", hit_count, 32'd2);
    chk32("stat_misses", miss_count, 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
